tx_sequencer: RTL and testbench
===============================

Name: tx_sequencer

Overview:
- Transmit-side counterpart to the receive sequencer in the radio comms path.
- Buffers outgoing bytes from the datapath in a small FIFO.
- For each byte, when the radio's TX-ready interrupt is high, drives the shared 16-bit SPI master through two transfers: a status-read command, then a TX-register write command {TX_CMD, byte}.
- Controls its own active-low slave select, tx_ss.

Parameters:
- n, 16: SPI word width; payload byte width is n/2.
- DEPTH, 4: input FIFO depth in bytes; power of 2, at least 2.
- TX_CMD, 8'hB8: upper n/2 bits of the TX-register write word.
- STATUS_CMD, 16'h0000: status-read word sent before every write.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting a new byte.
- tx_irq  in  1  radio TX register ready, active-high, already synchronised.
- spi_ready  in  1  single-cycle pulse from the SPI master when an n-bit transfer completes.
- data_in  in  n/2  byte to transmit.
- data_valid  in  1  data_in valid.
- data_ready  out  1  FIFO can accept; a push occurs when data_valid && data_ready.
- spi_data  out  n  word for the SPI master.
- spi_begin  out  1  one-cycle start pulse to the SPI master.
- tx_ss  out  1  radio slave select, active-low.
- busy  out  1  high whenever state != IDLE.
- fifo_count  out  $clog2(DEPTH)+1  bytes held.

Behaviour:
Reset (asynchronous):
- State = IDLE, FIFO emptied, spi_data = 0, spi_begin = 0, tx_ss = 1, busy = 0, data_ready = 1, fifo_count = 0.
- A reset mid-transfer abandons the byte immediately. The SPI master is reset by the same n_reset.

FSM states and transitions:
- IDLE: go to STATUS_BEGIN when !empty && enable && tx_irq; otherwise stay.
- STATUS_BEGIN: spi_begin = 1, tx_ss = 0, spi_data = STATUS_CMD. Go to STATUS_WAIT.
- STATUS_WAIT: tx_ss = 0. Go to GAP when spi_ready = 1.
- GAP: tx_ss = 1 for exactly one cycle, giving the radio a command boundary. Go to WRITE_BEGIN.
- WRITE_BEGIN: spi_begin = 1, tx_ss = 0, spi_data = {TX_CMD, FIFO head}. FIFO pops on this cycle's edge. Go to WRITE_WAIT.
- WRITE_WAIT: tx_ss = 0. Go to IDLE when spi_ready = 1.

Output timing and handshake rules:
- spi_data is a register. It takes its new value on the edge entering a BEGIN state and holds it until the next BEGIN state.
- spi_begin and tx_ss are decoded from the state register only, so they are glitch-free.
- spi_ready is ignored in IDLE, BEGIN and GAP states.
- tx_irq is sampled only in IDLE. A deassertion mid-sequence does not abort the byte.
- enable is sampled only in IDLE. Dropping it mid-sequence finishes the current byte, then holds in IDLE.
- Latency: IDLE to spi_begin takes 1 cycle. A full byte takes 4 + T_status + T_write cycles, where T_* is the number of cycles from spi_begin to the spi_ready pulse.
- Back-to-back bytes: after WRITE_WAIT returns to IDLE, the next byte starts on the following edge if its conditions hold. tx_ss is therefore high for at least 1 cycle between bytes.

FIFO:
- data_ready = !full. This is registered count logic, not combinational from the pop.
- A push while full cannot occur. There is no push-through-pop when full; data_ready stays 0 that cycle.
- Simultaneous push and pop when not full: count unchanged, data order preserved.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Decomposition:
- Package comms_pkg holds:
  - tx_state_t enum: IDLE, STATUS_BEGIN, STATUS_WAIT, GAP, WRITE_BEGIN, WRITE_WAIT.
  - Constants TX_CMD and STATUS_CMD (also used for the RX FIFO read command 16'hB000).
- Sub-module byte_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, wdata, rdata (head, show-ahead), full, empty, count.
  - Reusable by the receive path.

Test Plan:
- Reset then idle: n_reset low → tx_ss = 1, spi_begin = 0, spi_data = 16'h0000, data_ready = 1, busy = 0. With no data, the FSM stays in IDLE indefinitely even with tx_irq = 1.
- Single byte: push 8'hA5, enable = 1, tx_irq = 1, model spi_ready 8 cycles after each spi_begin.
  - Expect spi_begin with 16'h0000, then a one-cycle tx_ss high, then spi_begin with 16'hB8A5.
  - Then IDLE; fifo_count goes 1 → 0 on the WRITE_BEGIN edge.
- Gate on irq and enable:
  - Push 8'h3C with tx_irq = 0 → no spi_begin. Raise tx_irq → sequence starts the next cycle.
  - Repeat with enable = 0 → no start until enable = 1.
- FIFO full and order: push 8'h01..8'h05 with tx_irq = 0.
  - Expect data_ready = 0 after 4 pushes and byte 05 refused.
  - Release tx_irq → write words B801, B802, B803, B804 in order.
- Mid-sequence changes: drop tx_irq and enable during STATUS_WAIT → byte still completes with 16'hB8xx, then the FSM holds in IDLE. A simultaneous push during the WRITE_BEGIN pop leaves fifo_count unchanged.
- Reset mid-transfer: assert n_reset during WRITE_WAIT → tx_ss = 1 immediately, fifo_count = 0, spi_begin never re-pulses for the lost byte.

Source files
------------

// File: rtl/comms_pkg.sv
// Types and command constants shared by the radio comms transmit and receive sequencers.
package comms_pkg;
   typedef enum logic [2:0] {
      IDLE,
      STATUS_BEGIN,
      STATUS_WAIT,
      GAP,
      WRITE_BEGIN,
      WRITE_WAIT
   } tx_state_t;

   localparam logic [7:0]  TX_CMD      = 8'hB8;
   localparam logic [15:0] STATUS_CMD  = 16'h0000;
   localparam logic [15:0] RX_READ_CMD = 16'hB000;
endpackage

// File: rtl/byte_fifo.sv
// Small show-ahead FIFO with registered occupancy count; shared by the TX and RX paths.
// A push while full is dropped, and a pop while empty is ignored.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         mem_d[wptr_q] = wdata;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; the count gates every read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/tx_sequencer.sv
// Transmit sequencer: queues outgoing bytes and, per byte, drives the shared SPI master
// through a status read followed by a TX-register write, framing each with tx_ss.
//
// state        | meaning
// IDLE         | waiting for a queued byte, enable and tx_irq
// STATUS_BEGIN | start pulse for the status-read word
// STATUS_WAIT  | status transfer in flight
// GAP          | one cycle of tx_ss high between the two commands
// WRITE_BEGIN  | start pulse for {TX_CMD, byte}; FIFO head pops here
// WRITE_WAIT   | write transfer in flight
module tx_sequencer #(
   parameter int              n          = 16,
   parameter int              DEPTH      = 4,
   parameter logic [n/2-1:0]  TX_CMD     = comms_pkg::TX_CMD,
   parameter logic [n-1:0]    STATUS_CMD = comms_pkg::STATUS_CMD
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     enable,
   input  logic                     tx_irq,
   input  logic                     spi_ready,
   input  logic [n/2-1:0]           data_in,
   input  logic                     data_valid,
   output logic                     data_ready,
   output logic [n-1:0]             spi_data,
   output logic                     spi_begin,
   output logic                     tx_ss,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   import comms_pkg::tx_state_t;
   import comms_pkg::IDLE;
   import comms_pkg::STATUS_BEGIN;
   import comms_pkg::STATUS_WAIT;
   import comms_pkg::GAP;
   import comms_pkg::WRITE_BEGIN;
   import comms_pkg::WRITE_WAIT;

   tx_state_t      state_q, state_d;
   logic [n-1:0]   spi_data_q, spi_data_d;
   logic [n/2-1:0] fifo_head;
   logic           fifo_pop, fifo_full, fifo_empty;

   byte_fifo #(
      .WIDTH (n/2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .push    (data_valid),
      .pop     (fifo_pop),
      .wdata   (data_in),
      .rdata   (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign data_ready = !fifo_full;
   assign fifo_pop   = (state_q == WRITE_BEGIN);

   // Strobes decode straight from the state register so they cannot glitch.
   assign spi_begin  = (state_q == STATUS_BEGIN) || (state_q == WRITE_BEGIN);
   assign tx_ss      = (state_q == IDLE) || (state_q == GAP);
   assign busy       = (state_q != IDLE);
   assign spi_data   = spi_data_q;

   always_comb begin
      state_d    = state_q;
      spi_data_d = spi_data_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && enable && tx_irq) begin
               state_d    = STATUS_BEGIN;
               spi_data_d = STATUS_CMD;
            end
         end
         STATUS_BEGIN: state_d = STATUS_WAIT;
         STATUS_WAIT: begin
            if (spi_ready) state_d = GAP;
         end
         // Head is stable through GAP since nothing pops until WRITE_BEGIN.
         GAP: begin
            state_d    = WRITE_BEGIN;
            spi_data_d = {TX_CMD, fifo_head};
         end
         WRITE_BEGIN: state_d = WRITE_WAIT;
         WRITE_WAIT: begin
            if (spi_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= IDLE;
         spi_data_q <= '0;
      end else begin
         state_q    <= state_d;
         spi_data_q <= spi_data_d;
      end
   end
endmodule

// File: tb/tb_tx_sequencer.sv
// Directed bench for tx_sequencer: stimulus queues expected SPI words, a monitor
// compares them against each spi_begin, and a simple SPI master model answers with spi_ready.
module tb_tx_sequencer;
   logic        clk;
   logic        n_reset;
   logic        enable;
   logic        tx_irq;
   logic        spi_ready;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        data_ready;
   logic [15:0] spi_data;
   logic        spi_begin;
   logic        tx_ss;
   logic        busy;
   logic [2:0]  fifo_count;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_word;
   int          spi_cnt;

   tx_sequencer dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .enable     (enable),
      .tx_irq     (tx_irq),
      .spi_ready  (spi_ready),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .spi_data   (spi_data),
      .spi_begin  (spi_begin),
      .tx_ss      (tx_ss),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SPI master model: spi_ready pulses 8 cycles after each spi_begin.
   always @(negedge clk) begin
      if (!n_reset) begin
         spi_cnt   <= 0;
         spi_ready <= 1'b0;
      end else if (spi_begin) begin
         spi_cnt   <= 8;
         spi_ready <= 1'b0;
      end else begin
         spi_ready <= (spi_cnt == 1);
         spi_cnt   <= (spi_cnt != 0) ? spi_cnt - 1 : 0;
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (n_reset && spi_begin) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_begin: got %h expected no transfer", spi_data);
         end else begin
            exp_word = exp_q.pop_front();
            check("spi_word", spi_data, exp_word);
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back(16'h0000);
      exp_q.push_back({8'hB8, b});
   endtask

   task automatic wait_begin(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (spi_begin) break;
      end
      check(name, spi_begin, 1);
   endtask

   task automatic wait_ss_high(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_ss) break;
      end
      check(name, tx_ss, 1);
   endtask

   task automatic wait_idle(input string name, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check(name, busy, 0);
   endtask

   initial begin
      n_reset    = 1'b0;
      enable     = 1'b1;
      tx_irq     = 1'b1;
      data_in    = 8'h00;
      data_valid = 1'b0;

      // Reset and idle with no data
      repeat (3) @(negedge clk);
      check("rst_tx_ss", tx_ss, 1);
      check("rst_spi_begin", spi_begin, 0);
      check("rst_spi_data", spi_data, 16'h0000);
      check("rst_data_ready", data_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_fifo_count", fifo_count, 0);
      n_reset = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_no_data_busy", busy, 0);

      // Single byte
      expect_byte(8'hA5);
      push_byte(8'hA5);
      check("single_count_after_push", fifo_count, 1);
      wait_begin("single_status_begin");
      check("single_status_ss", tx_ss, 0);
      wait_ss_high("single_gap");
      check("single_gap_busy", busy, 1);
      @(negedge clk);
      check("single_write_begin", spi_begin, 1);
      check("single_write_ss", tx_ss, 0);
      check("single_count_at_pop", fifo_count, 1);
      @(negedge clk);
      check("single_count_after_pop", fifo_count, 0);
      check("single_write_wait_ss", tx_ss, 0);
      wait_idle("single_done", 30);
      check("single_idle_ss", tx_ss, 1);

      // Gate on tx_irq
      tx_irq = 1'b0;
      expect_byte(8'h3C);
      push_byte(8'h3C);
      repeat (10) @(negedge clk);
      check("irq_gate_busy", busy, 0);
      check("irq_gate_count", fifo_count, 1);
      tx_irq = 1'b1;
      @(negedge clk);
      check("irq_start_latency", spi_begin, 1);
      wait_idle("irq_done", 40);

      // Gate on enable
      enable = 1'b0;
      expect_byte(8'h5A);
      push_byte(8'h5A);
      repeat (10) @(negedge clk);
      check("en_gate_busy", busy, 0);
      enable = 1'b1;
      @(negedge clk);
      check("en_start_latency", spi_begin, 1);
      wait_idle("en_done", 40);

      // FIFO full and ordering
      tx_irq = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         expect_byte(8'(i));
         push_byte(8'(i));
      end
      check("full_data_ready", data_ready, 0);
      check("full_count", fifo_count, 4);
      push_byte(8'h05);
      check("full_refused_count", fifo_count, 4);
      tx_irq = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (fifo_count == 0 && !busy) break;
      end
      check("full_drain_count", fifo_count, 0);
      check("full_drain_ready", data_ready, 1);

      // Mid-sequence changes and simultaneous push/pop
      expect_byte(8'h77);
      push_byte(8'h77);
      wait_begin("mid_status_begin");
      @(negedge clk);
      tx_irq = 1'b0;
      enable = 1'b0;
      wait_ss_high("mid_gap");
      @(negedge clk);
      check("mid_write_begin", spi_begin, 1);
      check("mid_count_before", fifo_count, 1);
      data_in    = 8'h88;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      check("mid_count_push_pop", fifo_count, 1);
      wait_idle("mid_done", 30);
      repeat (10) @(negedge clk);
      check("mid_hold_idle", busy, 0);
      check("mid_hold_count", fifo_count, 1);
      expect_byte(8'h88);
      tx_irq = 1'b1;
      enable = 1'b1;
      wait_begin("mid_resume_begin");
      wait_idle("mid_resume_done", 40);

      // Reset during WRITE_WAIT
      expect_byte(8'h99);
      push_byte(8'h99);
      wait_begin("rstmid_status_begin");
      wait_ss_high("rstmid_gap");
      @(negedge clk);
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      check("rstmid_tx_ss", tx_ss, 1);
      check("rstmid_count", fifo_count, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_spi_data", spi_data, 16'h0000);
      @(negedge clk);
      n_reset = 1'b1;
      repeat (30) @(negedge clk);
      check("rstmid_stays_idle", busy, 0);
      check("exp_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
